jtag_cdc_dispatch: RTL and testbench

- System-clock-domain back end of the JTAG debug bridge.
- Receives a toggle-encoded command event from the TCK-domain DR engine, synchronises it, and routes the quasi-static command to one of NUM_CH bus-master channels over a req/ack handshake.
- Captures the selected channel's response and returns a completion toggle with a status code.
- Generalises the single-pulse, two-bus bridge: N channels, toggle CDC in both directions, channel decode errors, overrun detection and an ack timeout.

---
 rtl/jtag_cdc_dispatch_pkg.sv | 30 +++
 rtl/jtag_toggle_sync.sv | 32 +++
 rtl/jtag_cdc_dispatch.sv | 159 +++++++++++++++
 tb/tb_jtag_cdc_dispatch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_cdc_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_cdc_dispatch_pkg
// Brief    : Shared types and helpers for the JTAG system-clock dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_cdc_dispatch_pkg;

   localparam int STATUS_W = 3;

   typedef enum logic [1:0] {
      CODE_OK      = 2'b00,
      CODE_TIMEOUT = 2'b01,
      CODE_BADCH   = 2'b10,
      CODE_RSVD    = 2'b11
   } status_code_e;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'd0,
      FSM_LATCH = 2'd1,
      FSM_REQ   = 2'd2,
      FSM_DONE  = 2'd3
   } fsm_state_e;

   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_toggle_sync.sv
`default_nettype none
// ============================================================================
// Module   : jtag_toggle_sync
// Brief    : Multi-flop toggle synchroniser with a one-cycle edge pulse out.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_toggle_sync #(
   parameter int STAGES = 3
)(
   input  logic clk,
   input  logic TRSTn,
   input  logic tgl_i,
   output logic evt_o
);

   logic [STAGES-1:0] r_sync;
   logic              r_last;

   always_ff @(posedge clk or negedge TRSTn) begin
      if (!TRSTn) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], tgl_i};
         r_last <= r_sync[STAGES-1];
      end
   end

   assign evt_o = r_sync[STAGES-1] ^ r_last;

endmodule
`default_nettype wire

// File: rtl/jtag_cdc_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : jtag_cdc_dispatch
// Brief    : Routes toggle-signalled JTAG commands to NUM_CH req/ack channels.
//            Ack timeout is built only with JTAG_DISPATCH_TIMEOUT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_cdc_dispatch
   import jtag_cdc_dispatch_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int CMD_W       = 72,
   parameter  int RESP_W      = 34,
   parameter  int SYNC_STAGES = 3,
   parameter  int TIMEOUT_CYC = 255,
   localparam int CH_W        = ch_width(NUM_CH)
)(
   input  logic                     clk,
   input  logic                     TRSTn,
   input  logic                     cmd_tgl_i,
   input  logic [CH_W-1:0]          cmd_ch_i,
   input  logic [CMD_W-1:0]         cmd_i,
   output logic                     done_tgl_o,
   output logic [RESP_W-1:0]        resp_o,
   output logic [STATUS_W-1:0]      status_o,
   output logic                     busy_o,
   output logic [NUM_CH-1:0]        req_o,
   output logic [CMD_W-1:0]         cmd_o,
   input  logic [NUM_CH-1:0]        ack_i,
   input  logic [NUM_CH*RESP_W-1:0] resp_i
);

   localparam logic [1:0] c_S_IDLE  = FSM_IDLE;
   localparam logic [1:0] c_S_LATCH = FSM_LATCH;
   localparam logic [1:0] c_S_REQ   = FSM_REQ;
   localparam logic [1:0] c_S_DONE  = FSM_DONE;

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_num_ch
      $error("NUM_CH must be in 1..16");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_chk_timeout
      $error("TIMEOUT_CYC must be in 1..65535");
   end

   logic [1:0]        r_state;
   logic [CH_W-1:0]   r_ch;
   logic [1:0]        r_code;
   logic              r_ovr;
   logic              w_evt;
   logic              w_badch;
   logic              w_ack;
   logic [NUM_CH-1:0] w_onehot;
   logic [RESP_W-1:0] w_resp_sel;

`ifdef JTAG_DISPATCH_TIMEOUT_EN
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] r_cnt;
`endif

   jtag_toggle_sync #(
      .STAGES (SYNC_STAGES)
   ) u_cmd_sync (
      .clk   (clk),
      .TRSTn (TRSTn),
      .tgl_i (cmd_tgl_i),
      .evt_o (w_evt)
   );

   assign w_badch = (int'(cmd_ch_i) >= NUM_CH);
   assign busy_o  = (r_state != c_S_IDLE);
   // req_o is one-hot on the latched channel, so masking avoids indexing ack_i
   assign w_ack   = |(ack_i & req_o);

   always_comb begin
      w_onehot   = '0;
      w_resp_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(cmd_ch_i) == k) w_onehot[k] = 1'b1;
         if (int'(r_ch) == k)     w_resp_sel  = resp_i[k*RESP_W +: RESP_W];
      end
   end

   always_ff @(posedge clk or negedge TRSTn) begin
      if (!TRSTn) begin
         r_state    <= c_S_IDLE;
         r_ch       <= '0;
         r_code     <= CODE_OK;
         done_tgl_o <= 1'b0;
         resp_o     <= '0;
         status_o   <= '0;
         req_o      <= '0;
         cmd_o      <= '0;
`ifdef JTAG_DISPATCH_TIMEOUT_EN
         r_cnt      <= '0;
`endif
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_evt) r_state <= c_S_LATCH;
            end
            c_S_LATCH: begin
               cmd_o <= cmd_i;
               r_ch  <= cmd_ch_i;
               if (w_badch) begin
                  r_code  <= CODE_BADCH;
                  resp_o  <= '0;
                  r_state <= c_S_DONE;
               end else begin
`ifdef JTAG_DISPATCH_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
                  req_o   <= w_onehot;
                  r_state <= c_S_REQ;
               end
            end
            c_S_REQ: begin
               if (w_ack) begin
                  resp_o  <= w_resp_sel;
                  r_code  <= CODE_OK;
                  req_o   <= '0;
                  r_state <= c_S_DONE;
               end
`ifdef JTAG_DISPATCH_TIMEOUT_EN
               else if (r_cnt == c_TMO_LAST) begin
                  resp_o  <= '0;
                  r_code  <= CODE_TIMEOUT;
                  req_o   <= '0;
                  r_state <= c_S_DONE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            c_S_DONE: begin
               done_tgl_o <= ~done_tgl_o;
               status_o   <= {r_ovr, r_code};
               r_state    <= c_S_IDLE;
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   // An event landing in DONE must survive the clear and show up next time
   always_ff @(posedge clk or negedge TRSTn) begin
      if (!TRSTn) begin
         r_ovr <= 1'b0;
      end else if (r_state == c_S_DONE) begin
         r_ovr <= w_evt;
      end else if (w_evt && (r_state != c_S_IDLE)) begin
         r_ovr <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_cdc_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_cdc_dispatch
// Brief    : Self-checking bench for jtag_cdc_dispatch (4- and 3-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_cdc_dispatch;

   localparam int NCH = 4;
   localparam int CW  = 72;
   localparam int RW  = 34;
   localparam int SS  = 3;
   localparam int TMO = 8;
`ifdef JTAG_DISPATCH_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            TRSTn = 1'b0;
   logic            tgl = 1'b0;
   logic [1:0]      ch = '0;
   logic [CW-1:0]   cmd = '0;
   logic            done;
   logic [RW-1:0]   resp;
   logic [2:0]      status;
   logic            busy;
   logic [NCH-1:0]  req;
   logic [CW-1:0]   cmd_q;
   logic [NCH-1:0]  ack = '0;
   logic [NCH*RW-1:0] resp_in = '0;

   logic            tgl3 = 1'b0;
   logic [1:0]      ch3 = '0;
   logic [CW-1:0]   cmd3 = '0;
   logic            done3;
   logic [RW-1:0]   resp3;
   logic [2:0]      status3;
   logic            busy3;
   logic [2:0]      req3;
   logic [CW-1:0]   cmd3_q;
   logic [2:0]      ack3 = '0;
   logic [3*RW-1:0] resp_in3 = '0;

   int   total = 0;
   int   bad   = 0;
   logic m_done  = 1'b0;
   logic m_done3 = 1'b0;

   always #5 clk = ~clk;

   jtag_cdc_dispatch #(
      .NUM_CH(NCH), .CMD_W(CW), .RESP_W(RW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .TRSTn(TRSTn), .cmd_tgl_i(tgl), .cmd_ch_i(ch), .cmd_i(cmd),
      .done_tgl_o(done), .resp_o(resp), .status_o(status), .busy_o(busy),
      .req_o(req), .cmd_o(cmd_q), .ack_i(ack), .resp_i(resp_in)
   );

   jtag_cdc_dispatch #(
      .NUM_CH(3), .CMD_W(CW), .RESP_W(RW), .SYNC_STAGES(SS), .TIMEOUT_CYC(255)
   ) dut3 (
      .clk(clk), .TRSTn(TRSTn), .cmd_tgl_i(tgl3), .cmd_ch_i(ch3), .cmd_i(cmd3),
      .done_tgl_o(done3), .resp_o(resp3), .status_o(status3), .busy_o(busy3),
      .req_o(req3), .cmd_o(cmd3_q), .ack_i(ack3), .resp_i(resp_in3)
   );

   function automatic logic [CW-1:0] rnd_cmd();
      return {8'($urandom()), $urandom(), $urandom()};
   endfunction

   function automatic logic [RW-1:0] rnd_resp();
      return {2'($urandom()), $urandom()};
   endfunction

   // Reference outcome: an ack d cycles into REQ wins unless the timeout fired first
   function automatic logic [2:0] exp_status(input bit ovr, input int d);
      if (TMO_EN && d >= TMO) return {ovr, 2'b01};
      return {ovr, 2'b00};
   endfunction

   task automatic do_cmd(input int c, input logic [CW-1:0] cv, input int d,
                         input logic [RW-1:0] rv, input bit wrong, input bit ovr);
      logic [NCH-1:0] oh;
      bit             to;
      int             nreq;
      logic [2:0]     es;
      logic [RW-1:0]  er;
      oh   = NCH'(1) << c;
      to   = TMO_EN && (d >= TMO);
      nreq = to ? TMO : d + 1;
      es   = exp_status(ovr, d);
      er   = to ? '0 : rv;
      @(negedge clk);
      ch = c[1:0]; cmd = cv; tgl = ~tgl;
      for (int k = 1; k <= SS + 1; k++) begin
         @(negedge clk);
         total++;
         if (req !== '0) begin
            bad++; $display("FAIL req_early k=%0d got=%b want=0000", k, req);
         end
      end
      for (int i = 0; i < nreq; i++) begin
         @(negedge clk);
         total++;
         if (req !== oh) begin
            bad++; $display("FAIL req_held cyc=%0d got=%b want=%b", i, req, oh);
         end
         if (i == 0) begin
            total++;
            if (cmd_q !== cv || busy !== 1'b1) begin
               bad++; $display("FAIL cmd_latch got=%h/%b want=%h/1", cmd_q, busy, cv);
            end
         end
         if (ovr && i == 1) tgl = ~tgl;
         resp_in = {8'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
         ack = (wrong && i < d) ? NCH'(1) << ((c + 1) % NCH) : '0;
         if (!to && i == d) begin
            ack = oh;
            resp_in[c*RW +: RW] = rv;
         end
      end
      @(negedge clk);
      ack = '0;
      total++;
      if (req !== '0 || done !== m_done || busy !== 1'b1) begin
         bad++; $display("FAIL done_phase req=%b done=%b busy=%b want=0000/%b/1", req, done, busy, m_done);
      end
      m_done = ~m_done;
      @(negedge clk);
      total++;
      if (done !== m_done || resp !== er || status !== es || busy !== 1'b0 || cmd_q !== cv) begin
         bad++;
         $display("FAIL completion done=%b resp=%h status=%b busy=%b cmd=%h want %b/%h/%b/0/%h",
                  done, resp, status, busy, cmd_q, m_done, er, es, cv);
      end
   endtask

   task automatic test_reset();
      TRSTn = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({done, resp, status, busy, req, cmd_q} !== '0 ||
          {done3, resp3, status3, busy3, req3, cmd3_q} !== '0) begin
         bad++; $display("FAIL reset_state dut=%b/%h/%b/%b/%b dut3=%b/%b", done, resp, status, busy, req, done3, req3);
      end
      TRSTn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_cmd(2, 72'hA5, 3, 34'h1234, 1'b0, 1'b0);
   endtask

   task automatic test_badch();
      logic [RW-1:0] rv;
      logic [CW-1:0] cv;
      rv = rnd_resp() | 34'h1;
      cv = rnd_cmd();
      @(negedge clk);
      ch3 = 2'd1; cmd3 = cv; tgl3 = ~tgl3;
      repeat (SS + 2) @(negedge clk);
      total++;
      if (req3 !== 3'b010) begin
         bad++; $display("FAIL ch3_req got=%b want=010", req3);
      end
      ack3 = 3'b010;
      resp_in3 = {6'($urandom()), $urandom(), $urandom(), $urandom()};
      resp_in3[RW +: RW] = rv;
      @(negedge clk);
      ack3 = '0;
      m_done3 = ~m_done3;
      @(negedge clk);
      total++;
      if (done3 !== m_done3 || resp3 !== rv || status3 !== 3'b000) begin
         bad++; $display("FAIL ch3_ok done=%b resp=%h status=%b want %b/%h/000", done3, resp3, status3, m_done3, rv);
      end
      cv = rnd_cmd();
      @(negedge clk);
      ch3 = 2'd3; cmd3 = cv; tgl3 = ~tgl3;
      for (int k = 1; k <= SS + 2; k++) begin
         @(negedge clk);
         total++;
         if (req3 !== '0 || done3 !== m_done3) begin
            bad++; $display("FAIL badch_wait k=%0d req=%b done=%b want 000/%b", k, req3, done3, m_done3);
         end
      end
      m_done3 = ~m_done3;
      @(negedge clk);
      total++;
      if (done3 !== m_done3 || status3 !== 3'b010 || resp3 !== '0 || req3 !== '0 ||
          cmd3_q !== cv || busy3 !== 1'b0) begin
         bad++; $display("FAIL badch done=%b status=%b resp=%h req=%b want %b/010/0/000", done3, status3, resp3, req3, m_done3);
      end
   endtask

   task automatic test_timeout();
      do_cmd(0, rnd_cmd(), TMO_EN ? TMO + 3 : 40, rnd_resp(), 1'b0, 1'b0);
      do_cmd(1, rnd_cmd(), 2, rnd_resp(), 1'b0, 1'b0);
   endtask

   task automatic test_race();
      do_cmd(0, rnd_cmd(), TMO - 1, rnd_resp(), 1'b1, 1'b0);
   endtask

   task automatic test_overrun();
      do_cmd(3, rnd_cmd(), 5, rnd_resp(), 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++;
         if (req !== '0 || done !== m_done || busy !== 1'b0) begin
            bad++; $display("FAIL ovr_dropped k=%0d req=%b done=%b busy=%b want 0000/%b/0", k, req, done, busy, m_done);
         end
      end
      do_cmd(1, rnd_cmd(), 1, rnd_resp(), 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      ch = 2'd0; cmd = {CW{1'b1}}; tgl = ~tgl;
      repeat (SS + 2) @(negedge clk);
      total++;
      if (req !== 4'b0001) begin
         bad++; $display("FAIL pre_reset_req got=%b want=0001", req);
      end
      TRSTn = 1'b0; tgl = 1'b0; tgl3 = 1'b0;
      #1;
      total++;
      if ({done, resp, status, busy, req, cmd_q} !== '0) begin
         bad++; $display("FAIL async_reset done=%b resp=%h status=%b busy=%b req=%b cmd=%h want all 0",
                         done, resp, status, busy, req, cmd_q);
      end
      m_done = 1'b0; m_done3 = 1'b0;
      @(negedge clk);
      TRSTn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++;
         if (done !== 1'b0 || req !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset k=%0d done=%b req=%b busy=%b want 0/0000/0", k, done, req, busy);
         end
      end
      do_cmd(2, rnd_cmd(), 0, rnd_resp(), 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int c, d;
      bit w, o;
      for (int n = 0; n < 12; n++) begin
         c = $urandom_range(0, NCH - 1);
         d = $urandom_range(0, TMO_EN ? TMO + 2 : 15);
         w = 1'($urandom_range(0, 1));
         o = (d >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         do_cmd(c, rnd_cmd(), d, rnd_resp(), w, o);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) do_cmd(n, rnd_cmd(), n, rnd_resp(), 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_badch();
      test_timeout();
      test_race();
      test_overrun();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
